mfsk_modulator: RTL and testbench

Parametrised M-ary FSK modulator (M = 2^BITS_PER_SYM), successor to the fixed 4-FSK modulator. It accepts symbols over a valid/ready handshake. Each frame opens with an alternating-tone sync preamble. Each symbol is held for a fixed number of samples, and output is phase-continuous quadrature sine/cosine from a quarter-wave LUT. It sits between the symbol framer and the DAC/IQ output stage, with a matching demodulator on the receive side.

---
 rtl/mfsk_pkg.sv | 41 ++++
 rtl/mfsk_if.sv | 26 ++
 rtl/mfsk_sincos_lut.sv | 102 ++++++++++
 rtl/mfsk_modulator.sv | 161 ++++++++++++++++
 tb/tb_mfsk_modulator.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/mfsk_pkg.sv
// Shared types, constants and elaboration helpers for the M-ary FSK modulator.
// Increment and range helpers are constant functions evaluated at elaboration.
package mfsk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2
  } state_e;

  // Quadrant of the full-cycle LUT address (top two bits).
  localparam logic [1:0] QUAD_RISE   = 2'd0;
  localparam logic [1:0] QUAD_PEAK   = 2'd1;
  localparam logic [1:0] QUAD_FALL   = 2'd2;
  localparam logic [1:0] QUAD_TROUGH = 2'd3;

  function automatic longint unsigned tone_inc(input longint unsigned base,
                                               input longint unsigned step,
                                               input int unsigned     k,
                                               input int unsigned     width);
    longint unsigned raw;
    raw = base + 64'(k) * step;
    if (width >= 32'd64) begin
      return raw;
    end else begin
      return raw & ((64'd1 << width) - 64'd1);
    end
  endfunction

  function automatic bit bits_ok(input int unsigned bits);
    return (bits >= 32'd1) && (bits <= 32'd4);
  endfunction

  function automatic bit nyquist_ok(input longint unsigned base,
                                    input longint unsigned step,
                                    input int unsigned     bits,
                                    input int unsigned     width);
    return tone_inc(base, step, (32'd1 << bits) - 32'd1, width) < (64'd1 << (width - 32'd1));
  endfunction

endpackage

// File: rtl/mfsk_if.sv
// Symbol handshake and sample output bundle between framer, modulator and DAC stage.
interface mfsk_if #(
  parameter int BITS_PER_SYM = 3,
  parameter int OUT_WIDTH    = 18
);
  logic                        start;
  logic [BITS_PER_SYM-1:0]     sym_data;
  logic                        sym_last;
  logic                        sym_valid;
  logic                        sym_ready;
  logic signed [OUT_WIDTH-1:0] sine_out;
  logic signed [OUT_WIDTH-1:0] cos_out;
  logic                        out_valid;
  logic                        busy;
  logic                        underrun;

  modport master (
    output start, sym_data, sym_last, sym_valid,
    input  sym_ready, sine_out, cos_out, out_valid, busy, underrun
  );

  modport slave (
    input  start, sym_data, sym_last, sym_valid,
    output sym_ready, sine_out, cos_out, out_valid, busy, underrun
  );
endinterface

// File: rtl/mfsk_sincos_lut.sv
// Quarter-wave sine table with quadrant fold; two registered stages (read, then sign).
// Quadrants 1 and 3 mirror the index; index 0 there is the exact peak, held outside the table.
module mfsk_sincos_lut
  import mfsk_pkg::*;
#(
  parameter int LUT_ADDR_WIDTH = 10,
  parameter int OUT_WIDTH      = 18,
  parameter int AMP            = (1 << (OUT_WIDTH - 2)) - 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        en,
  input  logic [LUT_ADDR_WIDTH-1:0]   addr,
  output logic signed [OUT_WIDTH-1:0] sine,
  output logic signed [OUT_WIDTH-1:0] cos,
  output logic                        valid
);
  localparam int  QW     = LUT_ADDR_WIDTH - 2;
  localparam int  QN     = 1 << QW;
  localparam int  MW     = OUT_WIDTH - 1;
  localparam real TWO_PI = 6.283185307179586;
  localparam logic [MW-1:0] AMP_MAG = MW'(AMP);

  function automatic logic [MW-1:0] quarter_entry(input int i);
    real x;
    x = real'(AMP) * $sin(TWO_PI * real'(i) / real'(1 << LUT_ADDR_WIDTH));
    return MW'($rtoi(x + 0.5));
  endfunction

  // Returns {peak, table index} for a full-cycle address.
  function automatic logic [QW:0] fold(input logic [LUT_ADDR_WIDTH-1:0] a);
    logic [QW-1:0] idx;
    logic [QW:0]   r;
    idx = a[QW-1:0];
    case (a[LUT_ADDR_WIDTH-1 -: 2])
      QUAD_RISE, QUAD_FALL:   r = {1'b0, idx};
      QUAD_PEAK, QUAD_TROUGH: r = {(idx == '0), QW'(0) - idx};
      default:                r = {1'b0, idx};
    endcase
    return r;
  endfunction

  logic [MW-1:0] table_s [QN];
  for (genvar i = 0; i < QN; i++) begin : g_table
    assign table_s[i] = quarter_entry(i);
  end

  logic [LUT_ADDR_WIDTH-1:0] cos_addr_s;
  logic                      sin_peak_s, cos_peak_s;
  logic [QW-1:0]             sin_idx_s, cos_idx_s;
  logic [MW-1:0]             sin_mag_d, sin_mag_q, cos_mag_d, cos_mag_q;
  logic                      sin_neg_d, sin_neg_q, cos_neg_d, cos_neg_q;
  logic                      v1_q, valid_q;
  logic signed [OUT_WIDTH-1:0] sine_d, sine_q, cos_d, cos_q;

  // Stage-1 table read and stage-2 signed fold, zeroed when not valid.
  always_comb begin
    cos_addr_s               = addr + LUT_ADDR_WIDTH'(QN);
    {sin_peak_s, sin_idx_s}  = fold(addr);
    {cos_peak_s, cos_idx_s}  = fold(cos_addr_s);
    sin_mag_d = sin_peak_s ? AMP_MAG : table_s[sin_idx_s];
    cos_mag_d = cos_peak_s ? AMP_MAG : table_s[cos_idx_s];
    sin_neg_d = addr[LUT_ADDR_WIDTH-1];
    cos_neg_d = cos_addr_s[LUT_ADDR_WIDTH-1];
    sine_d    = '0;
    cos_d     = '0;
    if (v1_q) begin
      sine_d = sin_neg_q ? -$signed({1'b0, sin_mag_q}) : $signed({1'b0, sin_mag_q});
      cos_d  = cos_neg_q ? -$signed({1'b0, cos_mag_q}) : $signed({1'b0, cos_mag_q});
    end else begin
      sine_d = '0;
      cos_d  = '0;
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sin_mag_q <= '0;
      cos_mag_q <= '0;
      sin_neg_q <= 1'b0;
      cos_neg_q <= 1'b0;
      v1_q      <= 1'b0;
      valid_q   <= 1'b0;
      sine_q    <= '0;
      cos_q     <= '0;
    end else begin
      sin_mag_q <= sin_mag_d;
      cos_mag_q <= cos_mag_d;
      sin_neg_q <= sin_neg_d;
      cos_neg_q <= cos_neg_d;
      v1_q      <= en;
      valid_q   <= v1_q;
      sine_q    <= sine_d;
      cos_q     <= cos_d;
    end
  end

  assign sine  = sine_q;
  assign cos   = cos_q;
  assign valid = valid_q;
endmodule

// File: rtl/mfsk_modulator.sv
// M-ary FSK modulator: frame FSM with sync preamble, symbol handshake and
// phase-continuous accumulator feeding the quadrature sine/cosine LUT.
module mfsk_modulator
  import mfsk_pkg::*;
#(
  parameter int              BITS_PER_SYM    = 3,
  parameter int              PHASE_WIDTH     = 24,
  parameter int              LUT_ADDR_WIDTH  = 10,
  parameter int              OUT_WIDTH       = 18,
  parameter int              AMP             = (1 << (OUT_WIDTH - 2)) - 1,
  parameter int              SAMPLES_PER_SYM = 32,
  parameter int              SYNC_SYMS       = 8,
  parameter longint unsigned BASE_INC        = 64'd167772,
  parameter longint unsigned STEP_INC        = 64'd167772
) (
  input logic   clk,
  input logic   reset_n,
  mfsk_if.slave bus
);
  localparam int M   = 1 << BITS_PER_SYM;
  localparam int SCW = (SAMPLES_PER_SYM > 1) ? $clog2(SAMPLES_PER_SYM) : 1;
  localparam int YCW = (SYNC_SYMS > 1) ? $clog2(SYNC_SYMS) : 1;
  localparam logic [SCW-1:0]          SAMP_LAST = SCW'(SAMPLES_PER_SYM - 1);
  localparam logic [YCW-1:0]          SYNC_LAST = YCW'(SYNC_SYMS - 1);
  localparam logic [BITS_PER_SYM-1:0] TONE_TOP  = BITS_PER_SYM'(M - 1);

  if (!bits_ok(BITS_PER_SYM)) begin : g_bits_check
    $error("mfsk_modulator: BITS_PER_SYM must be in 1..4");
  end
  if (!nyquist_ok(BASE_INC, STEP_INC, BITS_PER_SYM, PHASE_WIDTH)) begin : g_nyquist_check
    $error("mfsk_modulator: highest tone increment reaches the Nyquist limit");
  end

  logic [PHASE_WIDTH-1:0] inc_table_s [M];
  for (genvar k = 0; k < M; k++) begin : g_inc
    assign inc_table_s[k] = PHASE_WIDTH'(tone_inc(BASE_INC, STEP_INC, k, PHASE_WIDTH));
  end

  function automatic logic ready_rule(input state_e st, input logic [SCW-1:0] samp,
                                      input logic [YCW-1:0] sym, input logic last);
    logic r;
    case (st)
      SYNC:    r = (samp == SAMP_LAST) && (sym == SYNC_LAST);
      DATA:    r = (samp == SAMP_LAST) && !last;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  state_e                  state_d, state_q;
  logic [SCW-1:0]          samp_cnt_d, samp_cnt_q;
  logic [YCW-1:0]          sym_cnt_d, sym_cnt_q;
  logic [BITS_PER_SYM-1:0] tone_d, tone_q;
  logic                    last_d, last_q;
  logic [PHASE_WIDTH-1:0]  phase_acc_d, phase_acc_q;
  logic                    underrun_d, underrun_q;
  logic                    busy_d, busy_q;
  logic                    sym_ready_d, sym_ready_q;
  logic                    boundary_s, ready_now_s;

  // Next-state, counters, handshake and phase step.
  always_comb begin
    state_d     = state_q;
    samp_cnt_d  = samp_cnt_q;
    sym_cnt_d   = sym_cnt_q;
    tone_d      = tone_q;
    last_d      = last_q;
    phase_acc_d = phase_acc_q;
    underrun_d  = underrun_q;
    boundary_s  = (samp_cnt_q == SAMP_LAST);
    ready_now_s = ready_rule(state_q, samp_cnt_q, sym_cnt_q, last_q);
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d     = SYNC;
          phase_acc_d = '0;
          samp_cnt_d  = '0;
          sym_cnt_d   = '0;
          tone_d      = '0;
          last_d      = 1'b0;
          underrun_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      SYNC, DATA: begin
        phase_acc_d = phase_acc_q + inc_table_s[tone_q];
        samp_cnt_d  = boundary_s ? '0 : samp_cnt_q + SCW'(1);
        if (!boundary_s) begin
          state_d = state_q;
        end else if (ready_now_s && bus.sym_valid) begin
          state_d = DATA;
          tone_d  = bus.sym_data;
          last_d  = bus.sym_last;
        end else if (ready_now_s) begin
          state_d    = IDLE;
          underrun_d = 1'b1;
        end else if (state_q == SYNC) begin
          // Preamble alternates tone 0 (even symbols) and tone M-1 (odd symbols).
          state_d   = SYNC;
          sym_cnt_d = sym_cnt_q + YCW'(1);
          tone_d    = sym_cnt_q[0] ? '0 : TONE_TOP;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d      = (state_d != IDLE);
    sym_ready_d = ready_rule(state_d, samp_cnt_d, sym_cnt_d, last_d);
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      samp_cnt_q  <= '0;
      sym_cnt_q   <= '0;
      tone_q      <= '0;
      last_q      <= 1'b0;
      phase_acc_q <= '0;
      underrun_q  <= 1'b0;
      busy_q      <= 1'b0;
      sym_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      samp_cnt_q  <= samp_cnt_d;
      sym_cnt_q   <= sym_cnt_d;
      tone_q      <= tone_d;
      last_q      <= last_d;
      phase_acc_q <= phase_acc_d;
      underrun_q  <= underrun_d;
      busy_q      <= busy_d;
      sym_ready_q <= sym_ready_d;
    end
  end

  logic signed [OUT_WIDTH-1:0] sine_s, cos_s;
  logic                        out_valid_s;

  mfsk_sincos_lut #(
    .LUT_ADDR_WIDTH(LUT_ADDR_WIDTH),
    .OUT_WIDTH     (OUT_WIDTH),
    .AMP           (AMP)
  ) u_lut (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (busy_q),
    .addr   (phase_acc_q[PHASE_WIDTH-1 -: LUT_ADDR_WIDTH]),
    .sine   (sine_s),
    .cos    (cos_s),
    .valid  (out_valid_s)
  );

  assign bus.sym_ready = sym_ready_q;
  assign bus.busy      = busy_q;
  assign bus.underrun  = underrun_q;
  assign bus.sine_out  = sine_s;
  assign bus.cos_out   = cos_s;
  assign bus.out_valid = out_valid_s;
endmodule

// File: tb/tb_mfsk_modulator.sv
// Randomised frame-level bench for mfsk_modulator with a schedule/phase reference model.
module tb_mfsk_modulator;
  localparam int BPS  = 3;
  localparam int PW   = 24;
  localparam int LAW  = 10;
  localparam int OW   = 18;
  localparam int AMP  = (1 << (OW - 2)) - 1;
  localparam int SPS  = 32;
  localparam int SYNC = 8;
  localparam longint BASE = 167772;
  localparam longint STEP = 167772;
  localparam int M    = 1 << BPS;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mfsk_if #(.BITS_PER_SYM(BPS), .OUT_WIDTH(OW)) bus ();

  mfsk_modulator #(
    .BITS_PER_SYM(BPS), .PHASE_WIDTH(PW), .LUT_ADDR_WIDTH(LAW), .OUT_WIDTH(OW),
    .AMP(AMP), .SAMPLES_PER_SYM(SPS), .SYNC_SYMS(SYNC),
    .BASE_INC(64'd167772), .STEP_INC(64'd167772)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  logic [LAW-1:0]       lut_addr;
  logic signed [OW-1:0] lut_sin, lut_cos;
  logic                 lut_valid;

  mfsk_sincos_lut #(.LUT_ADDR_WIDTH(LAW), .OUT_WIDTH(OW), .AMP(AMP)) u_lut_probe (
    .clk(clk), .reset_n(reset_n), .en(1'b1), .addr(lut_addr),
    .sine(lut_sin), .cos(lut_cos), .valid(lut_valid)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Ideal quadrature sample for a phase accumulator value, rounded half away from zero.
  function automatic longint exp_wave(input longint ph, input bit want_cos);
    real th, x;
    th = 2.0 * 3.141592653589793 * real'(ph >> (PW - LAW)) / real'(1 << LAW);
    x  = real'(AMP) * (want_cos ? $cos(th) : $sin(th));
    if (x >= 0.0) return longint'($rtoi(x + 0.5));
    else          return -longint'($rtoi(-x + 0.5));
  endfunction

  // One frame: u >= 0 drops sym_valid at data boundary u; reset_at > 0 resets in that cycle;
  // extra_start > 0 pulses start while busy in that cycle.
  task automatic run_frame(input int syms[$], input int u, input int reset_at, input int extra_start);
    int     nsyms, lastb, lc, t, b, tone;
    bit     bsy, bnd, rdy;
    longint ph[$];
    nsyms = syms.size();
    lastb = (u >= 0) ? u : nsyms - 1;
    lc    = (u >= 0) ? (SYNC + u) * SPS : (SYNC + nsyms) * SPS;
    ph.delete();
    ph.push_back(0);
    for (int i = 0; i < lc; i++) begin
      if (i / SPS < SYNC) tone = ((i / SPS) % 2 == 1) ? M - 1 : 0;
      else                tone = syms[i / SPS - SYNC];
      ph.push_back((ph[i] + BASE + longint'(tone) * STEP) & ((64'd1 << PW) - 1));
    end
    bus.start = 1'b1;
    for (int k = 1; k <= lc + 5; k++) begin
      @(posedge clk);
      #1;
      t   = k - 1;
      bsy = (t < lc);
      bnd = (t % SPS == SPS - 1) && (t / SPS >= SYNC - 1);
      b   = t / SPS - SYNC + 1;
      rdy = bsy && bnd && (b <= lastb);
      check_eq("busy", longint'(bus.busy), longint'(bsy));
      check_eq("sym_ready", longint'(bus.sym_ready), longint'(rdy));
      check_eq("underrun", longint'(bus.underrun), longint'(k > lc && u >= 0));
      check_eq("out_valid", longint'(bus.out_valid), longint'(k >= 3 && k <= lc + 2));
      if (k >= 3 && k <= lc + 2) begin
        check_eq("sine", longint'(bus.sine_out), exp_wave(ph[k-3], 1'b0));
        check_eq("cos", longint'(bus.cos_out), exp_wave(ph[k-3], 1'b1));
      end else begin
        check_eq("sine_idle", longint'(bus.sine_out), 0);
        check_eq("cos_idle", longint'(bus.cos_out), 0);
      end
      if (k == reset_at) begin
        reset_n = 1'b0;
        #1;
        check_eq("rst_busy", longint'(bus.busy), 0);
        check_eq("rst_ready", longint'(bus.sym_ready), 0);
        check_eq("rst_valid", longint'(bus.out_valid), 0);
        check_eq("rst_sine", longint'(bus.sine_out), 0);
        check_eq("rst_cos", longint'(bus.cos_out), 0);
        check_eq("rst_underrun", longint'(bus.underrun), 0);
        bus.start     = 1'b0;
        bus.sym_valid = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        return;
      end
      bus.start = (k == extra_start);
      if (rdy && b != u) begin
        bus.sym_valid = 1'b1;
        bus.sym_data  = BPS'(syms[b]);
        bus.sym_last  = (b == nsyms - 1);
      end else begin
        bus.sym_valid = rdy ? 1'b0 : 1'($urandom_range(0, 1));
        bus.sym_data  = BPS'($urandom_range(0, M - 1));
        bus.sym_last  = 1'($urandom_range(0, 1));
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic random_syms(input int n, output int q[$]);
    q.delete();
    for (int i = 0; i < n; i++) q.push_back(int'($urandom_range(0, M - 1)));
  endtask

  initial begin
    int q[$];
    int addrs[$];
    bus.start     = 1'b0;
    bus.sym_valid = 1'b0;
    bus.sym_data  = '0;
    bus.sym_last  = 1'b0;
    lut_addr      = '0;
    reset_n       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("init_busy", longint'(bus.busy), 0);
    check_eq("init_valid", longint'(bus.out_valid), 0);
    check_eq("init_sine", longint'(bus.sine_out), 0);
    check_eq("init_cos", longint'(bus.cos_out), 0);
    check_eq("init_underrun", longint'(bus.underrun), 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    q.delete();
    for (int i = 0; i < M; i++) q.push_back(i);
    run_frame(q, -1, -1, 100);
    repeat (2) begin
      random_syms(int'($urandom_range(3, 9)), q);
      run_frame(q, -1, -1, int'($urandom_range(2, 300)));
    end
    random_syms(6, q);
    run_frame(q, 2, -1, -1);
    random_syms(6, q);
    run_frame(q, -1, 300, -1);
    random_syms(int'($urandom_range(2, 5)), q);
    run_frame(q, -1, -1, -1);

    addrs = '{0, 256, 512, 768};
    repeat (8) addrs.push_back(int'($urandom_range(0, (1 << LAW) - 1)));
    foreach (addrs[i]) begin
      lut_addr = LAW'(addrs[i]);
      @(posedge clk);
      @(posedge clk);
      #1;
      check_eq("lut_valid", longint'(lut_valid), 1);
      check_eq("lut_sin", longint'(lut_sin), exp_wave(longint'(addrs[i]) << (PW - LAW), 1'b0));
      check_eq("lut_cos", longint'(lut_cos), exp_wave(longint'(addrs[i]) << (PW - LAW), 1'b1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
